moore_seq_driver: RTL

Programmable stimulus driver and checker for the six-state Moore FSM block (2-bit `in`, 2-bit `out`, synchronous active-high reset). The block drives the opposite end of that FSM's interface: it buffers a sequence of 2-bit input symbols, resets the FSM, and plays one symbol per cycle into it. It tracks the expected state with an internal shadow model, compares the FSM's `out` every step, and reports the first mismatch plus a total mismatch count. It sits in the test harness beside the FSM and connects to it only through `fsm_reset`, `fsm_in` and `fsm_out`.

---
 rtl/moore_seq_driver.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/moore_seq_driver.sv
// moore_seq_driver
//   Stimulus driver and checker for the six-state Moore FSM (2-bit in, 2-bit out).
//   A sequence of input symbols is buffered in a small FIFO while idle. On start
//   the driven FSM is reset for one cycle, then the symbols are played one per
//   cycle into it. A shadow copy of the FSM predicts its output and every step is
//   compared. The first mismatch is captured and all mismatches are counted.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   wr_valid, wr_data : symbol push (accepted when wr_ready)
//   wr_ready          : idle and FIFO not full (combinational)
//   start             : begin a run (sampled only while idle)
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   fsm_reset, fsm_in : registered drive into the FSM under test
//   fsm_out           : output of the FSM under test
//   err, err_step, err_exp, err_got : first-mismatch record (sticky per run)
//   err_count         : mismatches in the last run, saturating
module moore_seq_driver #(
  parameter int DEPTH = 8,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [1:0]    wr_data,
  output logic          wr_ready,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fsm_reset,
  output logic [1:0]    fsm_in,
  input  logic [1:0]    fsm_out,
  output logic          err,
  output logic [SW-1:0] err_step,
  output logic [1:0]    err_exp,
  output logic [1:0]    err_got,
  output logic [SW-1:0] err_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RST, RUN, DRAIN} ctrl_t;
  typedef enum logic [2:0] {S1, S2, S3, S4, S5, S6} shadow_t;

  function automatic shadow_t f_next(input shadow_t s, input logic [1:0] in);
    shadow_t n;
    n = S1;
    case (s)
      S1: case (in)
            2'd0: n = S1;
            2'd1: n = S3;
            2'd2: n = S5;
            default: n = S2;
          endcase
      S2: case (in)
            2'd1: n = S3;
            2'd2: n = S4;
            default: n = S2;
          endcase
      S3: n = in[1] ? S4 : S3;
      S4: n = S5;
      S5: case (in)
            2'd0: n = S4;
            2'd3: n = S6;
            default: n = S5;
          endcase
      default: n = S1;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] f_out(input shadow_t s);
    logic [1:0] o;
    o = 2'b01;
    case (s)
      S2, S5: o = 2'b10;
      S6:     o = 2'b11;
      default: o = 2'b01;
    endcase
    return o;
  endfunction

  logic [1:0]    r_mem [DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  ctrl_t         r_state;
  shadow_t       r_shadow;
  logic [SW-1:0] r_step;
  logic          r_busy, r_done, r_fsm_reset, r_err;
  logic [1:0]    r_fsm_in, r_err_exp, r_err_got;
  logic [SW-1:0] r_err_step, r_err_count;

  logic          w_empty, w_full, w_push, w_pop, w_check, w_mis;
  logic [1:0]    w_exp, w_head;

  always_comb begin
    w_empty  = (r_wptr == r_rptr);
    w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    wr_ready = (r_state == IDLE) && !w_full;
    w_push   = wr_valid && wr_ready;
    w_pop    = ((r_state == RST) || (r_state == RUN)) && !w_empty;
    w_head   = r_mem[r_rptr[AW-1:0]];
    // The FSM output seen in RUN/DRAIN cycles reflects the state reached by the
    // previous symbol (or reset), which is exactly what r_shadow holds.
    w_check  = (r_state == RUN) || (r_state == DRAIN);
    w_exp    = f_out(r_shadow);
    w_mis    = w_check && (fsm_out != w_exp);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_state     <= IDLE;
      r_shadow    <= S1;
      r_step      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fsm_reset <= 1'b0;
      r_fsm_in    <= '0;
      r_err       <= 1'b0;
      r_err_step  <= '0;
      r_err_exp   <= '0;
      r_err_got   <= '0;
      r_err_count <= '0;
    end else begin
      r_done      <= 1'b0;
      r_fsm_reset <= 1'b0;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;

      if (w_check) begin
        r_step   <= r_step + 1'b1;
        r_shadow <= f_next(r_shadow, r_fsm_in);
        if (w_mis) begin
          if (!r_err) begin
            r_err      <= 1'b1;
            r_err_step <= r_step;
            r_err_exp  <= w_exp;
            r_err_got  <= fsm_out;
          end
          if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= RST;
            r_busy      <= 1'b1;
            r_fsm_reset <= 1'b1;
            r_err       <= 1'b0;
            r_err_step  <= '0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
            r_err_count <= '0;
          end
        end
        RST, RUN: begin
          if (r_state == RST) begin
            r_shadow <= S1;
            r_step   <= '0;
          end
          if (!w_empty) begin
            r_fsm_in <= w_head;
            r_state  <= RUN;
          end else begin
            r_fsm_in <= '0;
            r_state  <= DRAIN;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_fsm_in <= '0;
        end
      endcase
    end
  end

  always_comb begin
    busy      = r_busy;
    done      = r_done;
    fsm_reset = r_fsm_reset;
    fsm_in    = r_fsm_in;
    err       = r_err;
    err_step  = r_err_step;
    err_exp   = r_err_exp;
    err_got   = r_err_got;
    err_count = r_err_count;
  end

endmodule
